// File: rtl/pitfall_frame_decider.sv
// rtl/pitfall_frame_decider.sv - per-pixel palette index: Harry sprite over banded jungle background
// Two-strobe pipeline; sprite position/mirror are shadowed at frame start to avoid mid-frame tearing.
module pitfall_frame_decider #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          SPR_W      = 16,
  parameter int          SPR_H      = 32,
  parameter int          N_FRAMES   = 4,
  parameter int          ANIM_DIV   = 6,
  parameter logic [5:0]  TRANSP_IDX = 6'd0,
  parameter logic [9:0]  BAND0_END  = 10'd160,
  parameter logic [9:0]  BAND1_END  = 10'd320,
  parameter logic [9:0]  BAND2_END  = 10'd400,
  parameter logic [5:0]  BAND0_IDX  = 6'd31,
  parameter logic [5:0]  BAND1_IDX  = 6'd35,
  parameter logic [5:0]  BAND2_IDX  = 6'd23,
  parameter logic [5:0]  BAND3_IDX  = 6'd0
) (
  input  logic                                         Clk,
  input  logic                                         Reset_n,
  input  logic                                         pixel_en,
  input  logic                                         frame_start,
  input  logic [9:0]                                   DrawX,
  input  logic [9:0]                                   DrawY,
  input  logic [9:0]                                   Harry_X,
  input  logic [9:0]                                   Harry_Y,
  input  logic                                         Harry_moving,
  input  logic                                         Harry_left,
  output logic [$clog2(N_FRAMES*SPR_W*SPR_H)-1:0]      rom_addr,
  input  logic [5:0]                                   rom_data,
  output logic [5:0]                                   value,
  output logic                                         value_valid
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam int FW = $clog2(N_FRAMES);
  localparam int NW = $clog2(ANIM_DIV);
  localparam logic [9:0]  H_LIM  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LIM  = 10'(V_ACTIVE);
  localparam logic [10:0] SW_LIM = 11'(SPR_W);
  localparam logic [10:0] SH_LIM = 11'(SPR_H);

  logic [9:0]    sh_x, sh_y;
  logic          sh_left;
  logic [FW-1:0] anim_frame;
  logic [NW-1:0] frame_cnt;

  logic [10:0]   dx, dy;
  logic          vis, hit;
  logic [CW-1:0] col;
  logic [5:0]    bg;
  logic [5:0]    spr_pix;

  logic          s1_vis, s1_hit, s2_vis, s2_hit;
  logic [5:0]    s1_bg, s2_bg;
  logic [5:0]    s1_rom, s2_rom;
  logic          pe_d1, pe_d2;

  always_comb begin
    vis = (DrawX < H_LIM) && (DrawY < V_LIM);
    dx  = {1'b0, DrawX} - {1'b0, sh_x};
    dy  = {1'b0, DrawY} - {1'b0, sh_y};
    hit = vis && (dx < SW_LIM) && (dy < SH_LIM);
    col = sh_left ? (CW'(SPR_W - 1) - dx[CW-1:0]) : dx[CW-1:0];
    if (DrawY < BAND0_END)      bg = BAND0_IDX;
    else if (DrawY < BAND1_END) bg = BAND1_IDX;
    else if (DrawY < BAND2_END) bg = BAND2_IDX;
    else                        bg = BAND3_IDX;
    // Back-to-back strobes leave no time to capture; take ROM data straight through.
    spr_pix = (pe_d1 && pe_d2) ? rom_data : s2_rom;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sh_x       <= '0;
      sh_y       <= '0;
      sh_left    <= 1'b0;
      anim_frame <= '0;
      frame_cnt  <= '0;
    end else if (frame_start) begin
      sh_x    <= Harry_X;
      sh_y    <= Harry_Y;
      sh_left <= Harry_left;
      if (!Harry_moving) begin
        frame_cnt  <= '0;
        anim_frame <= '0;
      end else if (frame_cnt == NW'(ANIM_DIV - 1)) begin
        frame_cnt  <= '0;
        anim_frame <= anim_frame + FW'(1);
      end else begin
        frame_cnt <= frame_cnt + NW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr    <= '0;
      s1_vis      <= 1'b0;
      s1_hit      <= 1'b0;
      s1_bg       <= '0;
      s2_vis      <= 1'b0;
      s2_hit      <= 1'b0;
      s2_bg       <= '0;
      value       <= '0;
      value_valid <= 1'b0;
    end else if (pixel_en) begin
      s1_vis <= vis;
      s1_hit <= hit;
      s1_bg  <= bg;
      if (hit) rom_addr <= {anim_frame, dy[RW-1:0], col};
      s2_vis <= s1_vis;
      s2_hit <= s1_hit;
      s2_bg  <= s1_bg;
      value_valid <= s2_vis;
      value <= !s2_vis ? 6'd0 :
               (s2_hit && spr_pix != TRANSP_IDX) ? spr_pix : s2_bg;
    end
  end

  // ROM data for a strobe is valid two Clks later; park it in whichever stage that pixel then occupies.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pe_d1  <= 1'b0;
      pe_d2  <= 1'b0;
      s1_rom <= '0;
      s2_rom <= '0;
    end else begin
      pe_d1 <= pixel_en;
      pe_d2 <= pe_d1;
      if (pixel_en) s2_rom <= s1_rom;
      if (pe_d2) begin
        if (!pe_d1 && !pixel_en)      s1_rom <= rom_data;
        else if (!(pe_d1 && pixel_en)) s2_rom <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_pitfall_frame_decider.sv
// tb/tb_pitfall_frame_decider.sv - scoreboard bench for pitfall_frame_decider
// Reference model predicts palette index and ROM address for every strobed pixel.
module tb_pitfall_frame_decider;

  logic        Clk = 1'b0;
  logic        Reset_n, pixel_en, frame_start, Harry_moving, Harry_left;
  logic [9:0]  DrawX, DrawY, Harry_X, Harry_Y;
  logic [10:0] rom_addr;
  logic [5:0]  rom_data = 6'd0;
  logic [5:0]  value;
  logic        value_valid;

  always #5 Clk = ~Clk;

  pitfall_frame_decider dut (
    .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pixel_en), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .Harry_X(Harry_X), .Harry_Y(Harry_Y),
    .Harry_moving(Harry_moving), .Harry_left(Harry_left), .rom_addr(rom_addr),
    .rom_data(rom_data), .value(value), .value_valid(value_valid)
  );

  // Synchronous sprite ROM: data = addr[5:0] (addr 0 gives the transparent index).
  always @(posedge Clk) rom_data <= (rom_addr == 11'd0) ? 6'd0 : rom_addr[5:0];

  int          checks = 0;
  int          errors = 0;
  logic [6:0]  sb_q[$];
  logic [6:0]  last_exp;
  bit          have_last = 0;
  int          m_shx, m_shy, m_anim, m_cnt;
  bit          m_left;
  logic [10:0] exp_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_shx = 0; m_shy = 0; m_left = 0; m_anim = 0; m_cnt = 0;
    exp_addr = 11'd0;
    sb_q.delete();
    have_last = 0;
  endtask

  task automatic frame_update();
    m_shx  = int'(Harry_X);
    m_shy  = int'(Harry_Y);
    m_left = Harry_left;
    if (!Harry_moving) begin
      m_cnt = 0; m_anim = 0;
    end else if (m_cnt == 5) begin
      m_cnt = 0; m_anim = (m_anim + 1) % 4;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      @(negedge Clk);
      frame_start = 1'b1;
      @(posedge Clk);
      #1;
      frame_start = 1'b0;
      frame_update();
    end
  endtask

  task automatic strobe(input int x, input int y, input bit fs, input int gap);
    int dx, dy, rd, bg;
    bit vis, hit;
    logic [6:0] e, got;
    vis = (x < 640) && (y < 480);
    dx  = x - m_shx;
    dy  = y - m_shy;
    hit = vis && dx >= 0 && dx < 16 && dy >= 0 && dy < 32;
    if (hit) exp_addr = 11'(m_anim * 512 + dy * 16 + (m_left ? 15 - dx : dx));
    rd  = int'(exp_addr) % 64;
    bg  = (y < 160) ? 31 : (y < 320) ? 35 : (y < 400) ? 23 : 0;
    e   = !vis ? 7'd0 : {1'b1, 6'((hit && rd != 0) ? rd : bg)};
    @(negedge Clk);
    DrawX = 10'(x); DrawY = 10'(y);
    pixel_en = 1'b1; frame_start = fs;
    @(posedge Clk);
    #1;
    pixel_en = 1'b0; frame_start = 1'b0;
    if (fs) frame_update();
    sb_q.push_back(e);
    check("rom_addr", 32'(rom_addr), 32'(exp_addr));
    if (sb_q.size() == 3) begin
      got = sb_q.pop_front();
      check("pixel", 32'({value_valid, value}), 32'(got));
      last_exp  = got;
      have_last = 1;
    end
    if (gap > 0) begin
      repeat (gap) @(posedge Clk);
      #1;
      if (have_last) check("hold", 32'({value_valid, value}), 32'(last_exp));
    end
  endtask

  task automatic flush(input int gap);
    strobe(650, 0, 0, gap);
    strobe(650, 0, 0, gap);
  endtask

  int px[8] = '{99, 100, 101, 102, 115, 116, 639, 5};
  int py[8] = '{200, 200, 200, 201, 231, 231, 479, 100};

  initial begin
    Reset_n = 1'b0; pixel_en = 1'b0; frame_start = 1'b0;
    DrawX = '0; DrawY = '0; Harry_X = '0; Harry_Y = '0;
    Harry_moving = 1'b0; Harry_left = 1'b0;
    model_reset();
    #12;
    check("reset_value", 32'(value), 0);
    check("reset_valid", 32'(value_valid), 0);
    check("reset_rom_addr", 32'(rom_addr), 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Background bands, no sprite on screen
    Harry_X = 10'd700; Harry_Y = 10'd0;
    pulse(1);
    strobe(5, 100, 0, 0); strobe(5, 200, 0, 0); strobe(5, 350, 0, 0);
    strobe(5, 450, 0, 0); strobe(650, 100, 0, 0);
    flush(0);

    // Sprite at (100,200), transparent corner and bottom-right pixel
    Harry_X = 10'd100; Harry_Y = 10'd200;
    pulse(1);
    strobe(100, 200, 0, 0); strobe(101, 200, 0, 0); strobe(115, 231, 0, 0);
    flush(0);

    // Mirrored
    Harry_left = 1'b1;
    pulse(1);
    strobe(100, 200, 0, 0); strobe(115, 200, 0, 0);
    flush(0);
    Harry_left = 1'b0;
    pulse(1);

    // Same pixel sequence with dense and sparse strobes
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 8; i++) strobe(px[i], py[i], 0, g);
      flush(g);
    end

    // Mid-frame position change only takes effect at frame_start
    Harry_X = 10'd300;
    strobe(101, 200, 0, 0);
    strobe(101, 200, 1, 0);
    strobe(101, 200, 0, 0);
    strobe(301, 200, 0, 0);
    flush(0);

    // Walk animation sequencing
    Harry_X = 10'd100; Harry_moving = 1'b1;
    pulse(6);
    strobe(101, 200, 0, 0);
    pulse(18);
    strobe(102, 200, 0, 0);
    pulse(6);
    strobe(103, 200, 0, 0);
    Harry_moving = 1'b0;
    pulse(1);
    strobe(104, 200, 0, 0);
    flush(0);

    // Reset with a full pipeline and nonzero animation frame
    Harry_moving = 1'b1;
    pulse(6);
    strobe(101, 200, 0, 0); strobe(102, 200, 0, 0); strobe(103, 200, 0, 0);
    #2;
    Reset_n = 1'b0;
    #1;
    check("midreset_value", 32'(value), 0);
    check("midreset_valid", 32'(value_valid), 0);
    check("midreset_rom_addr", 32'(rom_addr), 0);
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    Harry_moving = 1'b0;
    pulse(1);
    strobe(101, 200, 0, 0); strobe(5, 100, 0, 0);
    flush(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
